shift_sequencer: RTL and testbench

- Multi-cycle shift controller for the CPU datapath.
- Latches an operand and selects the shift amount source, using the same encoding as the shamt mux: instruction shamt field, B register [4:0], or constant 24.
- Shifts the operand iteratively, one bit per cycle, for SLL/SRL/SRA, SLLV/SRLV/SRAV and the byte-align shift by 24.
- Handshakes with the main control FSM through start/busy/done. Also drives the registered shamt-mux select so the datapath mux and the sequencer always agree.

---
 rtl/cpu_pkg.sv | 21 ++
 rtl/shift_step.sv | 21 ++
 rtl/shift_sequencer.sv | 114 +++++++++++
 tb/tb_shift_sequencer.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared shift-op, shamt-source and sequencer state encodings
package cpu_pkg;

  localparam logic [1:0] SH_SLL = 2'b00;
  localparam logic [1:0] SH_SRL = 2'b01;
  localparam logic [1:0] SH_SRA = 2'b10;

  // Same encoding as the datapath shamt mux select driven by main control.
  localparam logic [1:0] SHAMT_IMM   = 2'b00;
  localparam logic [1:0] SHAMT_B     = 2'b01;
  localparam logic [1:0] SHAMT_CONST = 2'b10;

  localparam int CONST_SHAMT = 24;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } seq_state_t;

endpackage

// File: rtl/shift_step.sv
// rtl/shift_step.sv - combinational one-bit shifter used once per SHIFT cycle
module shift_step #(
  parameter int DATA_W = 32
) (
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] data,
  output logic [DATA_W-1:0] shifted
);
  import cpu_pkg::*;

  // The reserved op encoding shifts left, same as SLL.
  always_comb begin
    case (op)
      SH_SLL:  shifted = {data[DATA_W-2:0], 1'b0};
      SH_SRL:  shifted = {1'b0, data[DATA_W-1:1]};
      SH_SRA:  shifted = {data[DATA_W-1], data[DATA_W-1:1]};
      default: shifted = {data[DATA_W-2:0], 1'b0};
    endcase
  end

endmodule

// File: rtl/shift_sequencer.sv
// rtl/shift_sequencer.sv - iterative one-bit-per-cycle shift controller with start/busy/done
module shift_sequencer #(
  parameter int DATA_W      = 32,
  parameter int CNT_W       = 5,
  parameter int CONST_SHAMT = cpu_pkg::CONST_SHAMT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        shift_op,
  input  logic [1:0]        src_sel,
  input  logic [4:0]        imm_shamt,
  input  logic [DATA_W-1:0] b_val,
  input  logic [DATA_W-1:0] a_val,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic [1:0]        shamt_sel,
  output logic [CNT_W-1:0]  shamt_val
);
  import cpu_pkg::*;

  seq_state_t        state, state_next;
  logic [DATA_W-1:0] shreg, shreg_next;
  logic [1:0]        op;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  amount;
  logic              accept;
  logic              last_step;
  logic              unused_b_bits;

  // Only the low CNT_W bits of B form a shift amount.
  assign unused_b_bits = ^b_val[DATA_W-1:CNT_W];

  always_comb begin
    case (src_sel)
      SHAMT_IMM:   amount = CNT_W'(imm_shamt);
      SHAMT_B:     amount = b_val[CNT_W-1:0];
      SHAMT_CONST: amount = CNT_W'(CONST_SHAMT);
      default:     amount = CNT_W'(CONST_SHAMT);
    endcase
  end

  assign accept    = (state == ST_IDLE) && start;
  assign last_step = (state == ST_SHIFT) && (cnt == CNT_W'(1));

  shift_step #(.DATA_W(DATA_W)) u_step (
    .op      (op),
    .data    (shreg),
    .shifted (shreg_next)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_next = (amount == '0) ? ST_DONE : ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        busy = 1'b1;
        if (cnt == CNT_W'(1)) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // result is only written when an operation completes, so a reset or a
  // long shift never exposes an intermediate value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shreg     <= '0;
      op        <= SH_SLL;
      cnt       <= '0;
      result    <= '0;
      shamt_sel <= SHAMT_IMM;
      shamt_val <= '0;
    end else if (accept) begin
      shreg     <= a_val;
      op        <= shift_op;
      cnt       <= amount;
      shamt_sel <= src_sel;
      shamt_val <= amount;
      if (amount == '0) begin
        result <= a_val;
      end
    end else if (state == ST_SHIFT) begin
      shreg <= shreg_next;
      cnt   <= cnt - CNT_W'(1);
      if (last_step) begin
        result <= shreg_next;
      end
    end
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// tb/tb_shift_sequencer.sv - directed and randomized checks of shift_sequencer against an arithmetic model
module tb_shift_sequencer;

  logic        clk;
  logic        reset;
  logic        start;
  logic [1:0]  shift_op;
  logic [1:0]  src_sel;
  logic [4:0]  imm_shamt;
  logic [31:0] b_val;
  logic [31:0] a_val;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [1:0]  shamt_sel;
  logic [4:0]  shamt_val;

  int checks = 0;
  int errors = 0;

  shift_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .shift_op  (shift_op),
    .src_sel   (src_sel),
    .imm_shamt (imm_shamt),
    .b_val     (b_val),
    .a_val     (a_val),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .shamt_sel (shamt_sel),
    .shamt_val (shamt_val)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] model_shift(input logic [1:0] op, input logic [31:0] a, input int n);
    case (op)
      2'b01:   return a >> n;
      2'b10:   return $signed(a) >>> n;
      default: return a << n;
    endcase
  endfunction

  function automatic int model_amount(input logic [1:0] src, input logic [4:0] imm, input logic [31:0] b);
    if (src == 2'b00) return int'(imm);
    if (src == 2'b01) return int'(b % 32);
    return 24;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic scramble_inputs();
    shift_op  = 2'($urandom);
    src_sel   = 2'($urandom);
    imm_shamt = 5'($urandom);
    b_val     = $urandom;
    a_val     = $urandom;
  endtask

  task automatic run_op(input logic [1:0] op, input logic [1:0] src, input logic [4:0] imm,
                        input logic [31:0] b, input logic [31:0] a, input bit noisy, input string tag);
    int n;
    int lat;
    int gaps;
    logic [31:0] exp;
    n    = model_amount(src, imm, b);
    exp  = model_shift(op, a, n);
    lat  = 0;
    gaps = 0;
    @(negedge clk);
    start = 1'b1; shift_op = op; src_sel = src; imm_shamt = imm; b_val = b; a_val = a;
    @(posedge clk);
    #1;
    start = 1'b0;
    scramble_inputs();
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (done) begin
        lat = k;
        break;
      end
      if (!busy) gaps++;
      if (noisy) begin
        start = 1'($urandom);
        scramble_inputs();
      end
    end
    start = 1'b0;
    check({tag, " latency"}, lat, n + 1);
    check({tag, " busy gaps"}, gaps, 0);
    check({tag, " busy at done"}, busy, 1'b1);
    check({tag, " result"}, result, exp);
    check({tag, " shamt_sel"}, shamt_sel, src);
    check({tag, " shamt_val"}, shamt_val, n);
    @(negedge clk);
    check({tag, " done pulse"}, done, 1'b0);
    check({tag, " idle busy"}, busy, 1'b0);
    check({tag, " result hold"}, result, exp);
  endtask

  initial begin
    int lat1;
    int lat2;
    int idle_busy;
    int dones;
    logic [1:0] rop;
    logic [1:0] rsrc;

    reset = 1'b0;
    start = 1'b0;
    shift_op = 2'b00; src_sel = 2'b00; imm_shamt = 5'd0; b_val = 32'h0; a_val = 32'h0;
    repeat (2) @(negedge clk);
    check("reset busy", busy, 1'b0);
    check("reset done", done, 1'b0);
    check("reset result", result, 32'h0);
    check("reset shamt_sel", shamt_sel, 2'b00);
    check("reset shamt_val", shamt_val, 5'd0);
    reset = 1'b1;
    @(negedge clk);

    run_op(2'b00, 2'b00, 5'd4, 32'h0, 32'h0000_0001, 1'b0, "sll imm");
    run_op(2'b10, 2'b01, 5'd9, 32'hFFFF_FFE3, 32'h8000_0000, 1'b0, "sra b");
    run_op(2'b01, 2'b10, 5'd3, 32'h0000_0007, 32'hAB00_0000, 1'b0, "srl const");
    run_op(2'b01, 2'b00, 5'd0, 32'h0, 32'h1234_5678, 1'b0, "zero amount");
    run_op(2'b11, 2'b11, 5'd1, 32'h0, 32'h0000_00FF, 1'b0, "reserved op const");

    // Back-to-back: start held high across the whole first operation.
    @(negedge clk);
    start = 1'b1; shift_op = 2'b01; src_sel = 2'b00; imm_shamt = 5'd3; b_val = 32'h0; a_val = 32'h0000_00F0;
    @(posedge clk);
    #1;
    shift_op = 2'b00; imm_shamt = 5'd31; a_val = 32'h0000_0001;
    lat1 = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (done) begin
        lat1 = k;
        break;
      end
    end
    check("b2b first latency", lat1, 4);
    check("b2b first result", result, 32'h0000_001E);
    lat2 = 0;
    idle_busy = 1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) idle_busy = busy;
      if (done) begin
        lat2 = k;
        break;
      end
    end
    start = 1'b0;
    check("b2b idle gap busy", idle_busy, 0);
    check("b2b second latency", lat2, 33);
    check("b2b second result", result, 32'h8000_0000);
    check("b2b second shamt_val", shamt_val, 5'd31);
    @(negedge clk);

    // Reset dropped part-way through a shift.
    start = 1'b1; shift_op = 2'b00; src_sel = 2'b00; imm_shamt = 5'd10; a_val = 32'h0000_0001;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("mid reset busy", busy, 1'b0);
    check("mid reset done", done, 1'b0);
    check("mid reset result", result, 32'h0);
    check("mid reset shamt_val", shamt_val, 5'd0);
    @(negedge clk);
    reset = 1'b1;
    dones = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("mid reset no done", dones, 0);
    check("mid reset result stays", result, 32'h0);

    for (int i = 0; i < 40; i++) begin
      rop  = 2'($urandom);
      rsrc = 2'($urandom);
      run_op(rop, rsrc, 5'($urandom), $urandom, $urandom, 1'b1, "random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
